// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Open-drain clock/data control with inhibit, framing, ACK and timeout.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic          clk_s1;
  logic          clk_s2;
  logic          clk_prev;
  logic          data_s1;
  logic          data_s2;
  logic [7:0]    byte_q;
  logic          par_q;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          fe;
  logic          active;
  logic          timeout;

  assign fe      = clk_prev & ~clk_s2;
  assign active  = (state == START) || (state == SHIFT) ||
                   (state == ACK)   || (state == WAIT_IDLE);
  assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle PS/2 lines are high, so synchronizers reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_async;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_async;
      data_s2  <= data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      byte_q      <= '0;
      par_q       <= 1'b0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (active && timeout) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        busy        <= 1'b0;
        tx_ready    <= 1'b1;
        tx_error    <= 1'b1;
        state       <= IDLE;
      end else begin
        if (active) begin
          to_cnt <= to_cnt + 1'b1;
        end
        unique case (state)
          IDLE: begin
            if (tx_valid && tx_ready) begin
              byte_q     <= tx_data;
              par_q      <= ~^tx_data;
              bit_cnt    <= '0;
              inh_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              busy       <= 1'b1;
              tx_ready   <= 1'b0;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
              ps2_data_oe <= 1'b1;
              to_cnt      <= '0;
              state       <= START;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          START: begin
            ps2_clk_oe <= 1'b0;
            state      <= SHIFT;
          end
          SHIFT: begin
            if (fe) begin
              bit_cnt <= bit_cnt + 1'b1;
              unique case (1'b1)
                (bit_cnt < 4'd8):
                  ps2_data_oe <= ~byte_q[bit_cnt[2:0]];
                (bit_cnt == 4'd8):
                  ps2_data_oe <= ~par_q;
                default: begin
                  ps2_data_oe <= 1'b0;
                  state       <= ACK;
                end
              endcase
            end
          end
          ACK: begin
            if (fe) begin
              if (!data_s2) begin
                state <= WAIT_IDLE;
              end else begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                busy        <= 1'b0;
                tx_ready    <= 1'b1;
                tx_error    <= 1'b1;
                state       <= IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            if (clk_s2 && data_s2) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b0;
              busy        <= 1'b0;
              tx_ready    <= 1'b1;
              tx_done     <= 1'b1;
              state       <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter: INHIBIT_CYCLES, default 5000, clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, default 750000, transfer timeout in clk cycles (15 ms at 50 MHz).
REQ-003 SHALL have port: clk  input  1  system clock (CLOCK_50 domain).
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: tx_data  input  8  command byte to send to the keyboard.
REQ-006 SHALL have port: tx_valid  input  1  request; a byte is accepted when tx_valid && tx_ready at a clk edge.
REQ-007 SHALL have port: tx_ready  output  1  high only in IDLE.
REQ-008 SHALL have port: ps2_clk_async  input  1  PS/2 clock line as read from the pin.
REQ-009 SHALL have port: ps2_data_async  input  1  PS/2 data line as read from the pin.
REQ-010 SHALL have port: ps2_clk_oe  output  1  1 = drive PS/2 clock low; 0 = release (open drain).
REQ-011 SHALL have port: ps2_data_oe  output  1  1 = drive PS/2 data low; 0 = release.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE; the receiver ignores the line while high.
REQ-013 SHALL have port: tx_done  output  1  one-cycle pulse when the device has acknowledged the byte.
REQ-014 SHALL have port: tx_error  output  1  one-cycle pulse on NACK or timeout.

Function
REQ-015 SHALL pass ps2_clk_async and ps2_data_async each through a 2-flop synchronizer; a falling edge (fe) is defined as previous synced clock 1 and current synced clock 0.
REQ-016 SHALL register all outputs and implement states IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe = 0, tx_ready = 1; on accept, latch tx_data, compute odd parity p = ~^tx_data, clear the bit counter, and go to INHIBIT.
REQ-018 INHIBIT: ps2_clk_oe = 1 and ps2_data_oe = 0 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-019 START: ps2_data_oe = 1 (start bit 0) with ps2_clk_oe = 1 for exactly one cycle; on the next cycle release the clock (ps2_clk_oe = 0) and go to SHIFT.
REQ-020 SHIFT: on each fe, present the next bit. On fe 1..8, ps2_data_oe = ~tx_data[fe-1] (LSB first). On fe 9, ps2_data_oe = ~p. On fe 10, ps2_data_oe = 0 (stop bit released). After fe 10, go to ACK.
REQ-021 ACK: on the next fe, sample the synced data. If 0, the byte is ACKed: go to WAIT_IDLE. If 1, it is a NACK: pulse tx_error and go to IDLE.
REQ-022 WAIT_IDLE: when synced clock and data are both 1, pulse tx_done and go to IDLE.
REQ-023 The timeout counter SHALL start at 0 on entering START and increment every cycle. If it reaches TIMEOUT_CYCLES in START, SHIFT, ACK or WAIT_IDLE: release both lines, pulse tx_error, and go to IDLE on that same edge.
REQ-024 tx_valid outside IDLE SHALL be ignored; the latched byte SHALL NOT change during a transfer.
REQ-025 An fe observed in IDLE or INHIBIT (device-initiated traffic) SHALL be ignored and SHALL have no effect.
REQ-026 tx_done and tx_error SHALL never be high in the same cycle. In the cycle after either pulse, tx_ready SHALL be 1.
REQ-027 Timeout has priority over an fe in the same cycle.

Reset
REQ-028 With reset high at a clk edge, the block SHALL enter IDLE with ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0, tx_ready = 1, tx_done = 0, tx_error = 0, and all counters and synchronizers reset to 1/idle. This applies mid-transfer too: both lines SHALL be released at that edge.

Verification
REQ-029 Send 0xF4; the device model clocks 11 falling edges and pulls data low on the 11th → bits 0,0,1,0,1,1,1,1, parity 0, stop released; tx_done pulses exactly once.
REQ-030 Send 0xED → ps2_clk_oe high for exactly 5000 cycles, then one cycle with both oe = 1; parity bit driven = 1.
REQ-031 Send 0x00; the device leaves data high at the ack fe → tx_error pulses once, no tx_done, and the block returns to IDLE.
REQ-032 Send 0x01; the device never clocks → at 750000 cycles after START, tx_error pulses and both oe = 0.
REQ-033 Assert reset at fe 5 of a transfer → next edge: both oe = 0, tx_ready = 1; a new 0xFF request afterwards completes with parity 1.
REQ-034 Hold tx_valid with changing tx_data during a transfer → only the first byte is transmitted; one tx_done.
